// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// The HALT state only exists when ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
        ,S_HALT    = 4'd11
`endif
    } statetype_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus instruction funct fields to an ALU operation.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // funct7b5 is only a sub flag for R-type; for addi it is immediate data
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32I datapath; ILLEGAL_TRAP_EN adds a HALT trap.
// FETCH ir+pc+4 | DECODE br target | MEMADR/MEMREAD/MEMWB lw | MEMWRITE sw
// EXECUTER/EXECUTEI alu | ALUWB rd write | BEQ compare | JAL link+jump | HALT illegal op
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic [1:0]         imm_src,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic               reg_write,
    output logic [STATE_W-1:0] state_o
`ifdef ILLEGAL_TRAP_EN
    ,output logic              illegal_op
`endif
);

    statetype_t state_q, state_d;
    logic       pc_update, branch, ir_write_s, reg_write_s, mem_write_s;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    // Reset can land mid-instruction; gating here keeps that cycle from committing anything.
    assign pc_write  = (pc_update | (branch & zero)) & ~reset;
    assign ir_write  = ir_write_s & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign state_o   = STATE_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_HALT);
`endif

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule
